// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of a slow asynchronous square wave in clk cycles.
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   sig_in       asynchronous wave under measurement
//   enable       measurement enable; low forces IDLE
//   period       last complete period in clk cycles
//   high_time    high time of that same period
//   meas_valid   one-cycle pulse when period/high_time update
//   timeout      sticky flag: no rising edge within TIMEOUT cycles
module clock_period_meter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             enable,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout
);
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
  localparam logic [WIDTH-1:0] TO = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic s, s_d_q, rise, fall, at_to;
  logic [WIDTH-1:0] cnt_q, cnt_d, hi_q, hi_d, period_q, period_d, high_q, high_d;
  logic valid_q, valid_d, to_q, to_d;
  assign sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
  assign s = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;
  assign at_to = cnt_q == TO;
  // A rise always wins over a coincident timeout; enable low overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + ONE;
    hi_d = hi_q;
    period_d = period_q;
    high_d = high_q;
    valid_d = 1'b0;
    to_d = to_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d = '0;
        end
        ARM: begin
          if (rise) begin
            state_d = MEAS;
            cnt_d = ONE;
          end else if (at_to) begin
            to_d = 1'b1;
            cnt_d = '0;
          end
        end
        MEAS: begin
          if (fall) hi_d = cnt_q;
          if (rise) begin
            period_d = cnt_q;
            high_d = fall ? cnt_q : hi_q;
            valid_d = 1'b1;
            to_d = 1'b0;
            cnt_d = ONE;
          end else if (at_to) begin
            to_d = 1'b1;
            cnt_d = '0;
            state_d = ARM;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q <= '0;
      s_d_q <= 1'b0;
      cnt_q <= '0;
      hi_q <= '0;
      period_q <= '0;
      high_q <= '0;
      valid_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      s_d_q <= s;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      period_q <= period_d;
      high_q <= high_d;
      valid_q <= valid_d;
      to_q <= to_d;
    end
  end
  assign period = period_q;
  assign high_time = high_q;
  assign meas_valid = valid_q;
  assign timeout = to_q;
endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: directed self-checking bench for clock_period_meter.
module tb_clock_period_meter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sig_in = 1'b0;
  logic enable = 1'b0;
  logic [15:0] period, high_time;
  logic meas_valid, timeout;
  int vectors = 0, miscompares = 0;
  int cyc = 0, vcount = 0, first_vc = -1, last_vc = -1, w0 = 0, to_cyc = -1;
  logic [15:0] last_p = '0, last_h = '0;

  clock_period_meter #(.WIDTH(16), .SYNC_STAGES(2), .TIMEOUT(200)) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .enable(enable),
    .period(period), .high_time(high_time), .meas_valid(meas_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (meas_valid) begin
      vcount++;
      last_p = period;
      last_h = high_time;
      last_vc = cyc;
      if (first_vc < 0) first_vc = cyc;
    end
  endtask

  task automatic clr();
    vcount = 0;
    first_vc = -1;
    last_vc = -1;
    w0 = cyc;
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int k = 0; k < n; k++) begin
      sig_in = 1'b1;
      repeat (h) tick();
      sig_in = 1'b0;
      repeat (l) tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    sig_in = 1'b0;
    repeat (3) tick();
    vectors++; if (period !== 16'd0) begin miscompares++; $display("FAIL reset_period: got %0d want 0", period); end
    vectors++; if (high_time !== 16'd0) begin miscompares++; $display("FAIL reset_high: got %0d want 0", high_time); end
    vectors++; if (meas_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", meas_valid); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", timeout); end
  endtask

  task automatic test_nominal();
    reset = 1'b0;
    repeat (2) tick();
    clr();
    wave(50, 50, 4);
    vectors++; if (vcount !== 3) begin miscompares++; $display("FAIL nominal_count: got %0d want 3", vcount); end
    vectors++; if (last_p !== 16'd100) begin miscompares++; $display("FAIL nominal_period: got %0d want 100", last_p); end
    vectors++; if (last_h !== 16'd50) begin miscompares++; $display("FAIL nominal_high: got %0d want 50", last_h); end
    vectors++; if (first_vc - w0 !== 103) begin miscompares++; $display("FAIL nominal_latency: got %0d want 103", first_vc - w0); end
    vectors++; if (last_vc - first_vc !== 200) begin miscompares++; $display("FAIL nominal_spacing: got %0d want 200", last_vc - first_vc); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL nominal_timeout: got %b want 0", timeout); end
  endtask

  task automatic test_asym();
    clr();
    wave(7, 13, 5);
    vectors++; if (vcount !== 5) begin miscompares++; $display("FAIL asym_count: got %0d want 5", vcount); end
    vectors++; if (last_p !== 16'd20) begin miscompares++; $display("FAIL asym_period: got %0d want 20", last_p); end
    vectors++; if (last_h !== 16'd7) begin miscompares++; $display("FAIL asym_high: got %0d want 7", last_h); end
    vectors++; if (last_vc - first_vc !== 80) begin miscompares++; $display("FAIL asym_spacing: got %0d want 80", last_vc - first_vc); end
  endtask

  task automatic test_timeout();
    to_cyc = -1;
    for (int i = 0; i < 400 && to_cyc < 0; i++) begin
      tick();
      if (timeout) to_cyc = cyc;
    end
    vectors++; if (to_cyc - last_vc !== 200) begin miscompares++; $display("FAIL timeout_delay: got %0d want 200", to_cyc - last_vc); end
    vectors++; if (period !== 16'd20) begin miscompares++; $display("FAIL timeout_period_hold: got %0d want 20", period); end
    clr();
    wave(50, 50, 3);
    vectors++; if (vcount !== 2) begin miscompares++; $display("FAIL restart_count: got %0d want 2", vcount); end
    vectors++; if (first_vc - w0 !== 103) begin miscompares++; $display("FAIL restart_latency: got %0d want 103", first_vc - w0); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL restart_timeout: got %b want 0", timeout); end
    vectors++; if (last_p !== 16'd100) begin miscompares++; $display("FAIL restart_period: got %0d want 100", last_p); end
  endtask

  task automatic test_enable_gate();
    clr();
    repeat (20) tick();
    sig_in = 1'b1;
    repeat (2) tick();
    enable = 1'b0;
    tick();
    repeat (47) tick();
    sig_in = 1'b0;
    repeat (50) tick();
    vectors++; if (vcount !== 0) begin miscompares++; $display("FAIL gate_count: got %0d want 0", vcount); end
    vectors++; if (period !== 16'd100) begin miscompares++; $display("FAIL gate_period_hold: got %0d want 100", period); end
    vectors++; if (high_time !== 16'd50) begin miscompares++; $display("FAIL gate_high_hold: got %0d want 50", high_time); end
    enable = 1'b1;
    repeat (2) tick();
    clr();
    wave(30, 30, 3);
    vectors++; if (vcount !== 2) begin miscompares++; $display("FAIL reenable_count: got %0d want 2", vcount); end
    vectors++; if (first_vc - w0 !== 63) begin miscompares++; $display("FAIL reenable_latency: got %0d want 63", first_vc - w0); end
    vectors++; if (last_p !== 16'd60) begin miscompares++; $display("FAIL reenable_period: got %0d want 60", last_p); end
  endtask

  task automatic test_min_period();
    clr();
    wave(2, 2, 6);
    vectors++; if (vcount !== 6) begin miscompares++; $display("FAIL min_count: got %0d want 6", vcount); end
    vectors++; if (last_p !== 16'd4) begin miscompares++; $display("FAIL min_period: got %0d want 4", last_p); end
    vectors++; if (last_h !== 16'd2) begin miscompares++; $display("FAIL min_high: got %0d want 2", last_h); end
    vectors++; if (last_vc - first_vc !== 20) begin miscompares++; $display("FAIL min_spacing: got %0d want 20", last_vc - first_vc); end
  endtask

  task automatic test_reset_mid();
    sig_in = 1'b1;
    repeat (10) tick();
    reset = 1'b1;
    #1;
    vectors++; if (period !== 16'd0) begin miscompares++; $display("FAIL midreset_period: got %0d want 0", period); end
    vectors++; if (high_time !== 16'd0) begin miscompares++; $display("FAIL midreset_high: got %0d want 0", high_time); end
    vectors++; if (meas_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid: got %b want 0", meas_valid); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL midreset_timeout: got %b want 0", timeout); end
    repeat (2) tick();
    sig_in = 1'b0;
    reset = 1'b0;
    repeat (2) tick();
    clr();
    wave(50, 50, 2);
    vectors++; if (vcount !== 1) begin miscompares++; $display("FAIL midreset_count: got %0d want 1", vcount); end
    vectors++; if (first_vc - w0 !== 103) begin miscompares++; $display("FAIL midreset_latency: got %0d want 103", first_vc - w0); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_asym();
    test_timeout();
    test_enable_gate();
    test_min_period();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
